speed_run_ctrl: RTL and testbench

Run/pause and speed controller for the user design's animated output datapath. It synchronizes and debounces the three push-buttons (pause, faster, slower). A two-state run FSM and a saturating speed-level register sit behind the buttons. The block emits a one-cycle step_tick that advances the downstream pattern/counter datapath at the selected rate. It sits between ui_in[2:0] and the display datapath in the top-level tt_um wrapper.

---
 rtl/speed_run_ctrl.sv | 115 +++++++++++
 tb/tb_speed_run_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/speed_run_ctrl.sv
// Run/pause and speed-level controller: synchronizes and debounces three push-buttons,
// runs a PAUSED/RUNNING FSM, keeps a saturating speed level and emits a periodic step_tick.
module speed_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BASE_PERIOD     = 25000000,
  parameter int NUM_LEVELS      = 8,
  parameter int DEFAULT_LEVEL   = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pause_btn,
  input  logic                          faster_btn,
  input  logic                          slower_btn,
  output logic                          running,
  output logic [$clog2(NUM_LEVELS)-1:0] speed_level,
  output logic                          step_tick,
  output logic [2:0]                    btn_evt
);

  localparam int LW = $clog2(NUM_LEVELS);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(BASE_PERIOD);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LVL_MAX = LW'(NUM_LEVELS - 1);
  localparam logic [LW-1:0] LVL_DEF = LW'(DEFAULT_LEVEL);

  typedef enum logic {
    PAUSED  = 1'b0,
    RUNNING = 1'b1
  } run_state_t;

  run_state_t    state;
  logic [2:0]    raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    deb;
  logic [DW-1:0] db_cnt [3];
  logic [PW-1:0] per_cnt;
  logic [PW-1:0] per_last;
  logic [31:0]   per_full;
  logic          lvl_up;
  logic          lvl_dn;

  assign raw     = {slower_btn, faster_btn, pause_btn};
  assign running = (state == RUNNING);

  // Saturated speed presses are not level changes, so they must not restart the period.
  always_comb begin
    per_full = 32'(BASE_PERIOD) >> speed_level;
    per_last = PW'(per_full - 32'd1);
    lvl_up   = btn_evt[1] && !btn_evt[2] && (speed_level != LVL_MAX);
    lvl_dn   = btn_evt[2] && !btn_evt[1] && (speed_level != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      deb     <= '0;
      btn_evt <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int unsigned i = 0; i < 3; i++) begin
        btn_evt[i] <= 1'b0;
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]     <= ~deb[i];
          db_cnt[i]  <= '0;
          btn_evt[i] <= ~deb[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PAUSED;
      speed_level <= LVL_DEF;
      per_cnt     <= '0;
      step_tick   <= 1'b0;
    end else begin
      step_tick <= 1'b0;
      if (btn_evt[0]) begin
        case (state)
          PAUSED:  state <= RUNNING;
          RUNNING: state <= PAUSED;
          default: state <= PAUSED;
        endcase
      end
      if (lvl_up) begin
        speed_level <= speed_level + 1'b1;
      end else if (lvl_dn) begin
        speed_level <= speed_level - 1'b1;
      end
      if (lvl_up || lvl_dn) begin
        per_cnt <= '0;
      end else if (state == RUNNING) begin
        if (per_cnt == per_last) begin
          per_cnt   <= '0;
          step_tick <= 1'b1;
        end else begin
          per_cnt <= per_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_speed_run_ctrl.sv
// Directed bench for speed_run_ctrl with small debounce and period parameters.
module tb_speed_run_ctrl;

  logic       clk;
  logic       rst_n;
  logic [2:0] raw;
  logic       running;
  logic [1:0] speed_level;
  logic       step_tick;
  logic [2:0] btn_evt;

  int checks;
  int errors;

  int cyc;
  int tick_log[$];
  int evt_cnt[3];
  int evt_cyc[3];
  int run_rise;
  int run_fall;
  int lvl_chg;
  logic       prev_run;
  logic [1:0] prev_lvl;

  speed_run_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .BASE_PERIOD(64),
    .NUM_LEVELS(4),
    .DEFAULT_LEVEL(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pause_btn(raw[0]),
    .faster_btn(raw[1]),
    .slower_btn(raw[2]),
    .running(running),
    .speed_level(speed_level),
    .step_tick(step_tick),
    .btn_evt(btn_evt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 3; i++) begin
      evt_cnt[i] = 0;
      evt_cyc[i] = -1;
    end
    run_rise = -1;
    run_fall = -1;
    lvl_chg  = -1;
    prev_run = 1'b0;
    prev_lvl = 2'd1;
  end

  always @(negedge clk) begin
    if (step_tick) tick_log.push_back(cyc);
    for (int i = 0; i < 3; i++) begin
      if (btn_evt[i]) begin
        evt_cnt[i] = evt_cnt[i] + 1;
        evt_cyc[i] = cyc;
      end
    end
    if (running && !prev_run) run_rise = cyc;
    if (!running && prev_run) run_fall = cyc;
    if (speed_level != prev_lvl) lvl_chg = cyc;
    prev_run = running;
    prev_lvl = speed_level;
  end

  function automatic int first_tick_after(input int c);
    foreach (tick_log[i]) begin
      if (tick_log[i] > c) return tick_log[i];
    end
    return -1;
  endfunction

  int raise_cyc;

  task automatic press(input logic [2:0] mask, input int hold, input int rel);
    @(posedge clk);
    #1;
    raw = raw | mask;
    raise_cyc = cyc;
    repeat (hold) @(posedge clk);
    #1;
    raw = raw & ~mask;
    repeat (rel) @(posedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    raw   = 3'b000;
    #100;
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL rst_running got %b want 0", running); end
    checks++; if (speed_level !== 2'd1) begin errors++; $display("FAIL rst_level got %0d want 1", speed_level); end
    checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL rst_tick got %b want 0", step_tick); end
    checks++; if (btn_evt !== 3'b000) begin errors++; $display("FAIL rst_evt got %b want 000", btn_evt); end
    #200;
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL idle_running got %b want 0", running); end
    checks++; if (speed_level !== 2'd1) begin errors++; $display("FAIL idle_level got %0d want 1", speed_level); end
    checks++; if (tick_log.size() != 0) begin errors++; $display("FAIL idle_ticks got %0d want 0", tick_log.size()); end
    checks++; if (evt_cnt[0] + evt_cnt[1] + evt_cnt[2] != 0) begin errors++; $display("FAIL idle_evts got %0d want 0", evt_cnt[0] + evt_cnt[1] + evt_cnt[2]); end
  endtask

  task automatic test_pause;
    int e0;
    int t1;
    int t2;
    e0 = evt_cnt[0];
    press(3'b001, 15, 110);
    @(negedge clk);
    checks++; if (evt_cnt[0] - e0 != 1) begin errors++; $display("FAIL pause_evt_count got %0d want 1", evt_cnt[0] - e0); end
    checks++; if (evt_cyc[0] - raise_cyc < 5 || evt_cyc[0] - raise_cyc > 7) begin errors++; $display("FAIL pause_latency got %0d want 5..7", evt_cyc[0] - raise_cyc); end
    checks++; if (run_rise - evt_cyc[0] != 1) begin errors++; $display("FAIL pause_fsm_delay got %0d want 1", run_rise - evt_cyc[0]); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL pause_running got %b want 1", running); end
    t1 = first_tick_after(run_rise);
    t2 = first_tick_after(t1);
    checks++; if (t1 - run_rise != 32) begin errors++; $display("FAIL first_tick_l1 got %0d want 32", t1 - run_rise); end
    checks++; if (t1 < 0 || t2 - t1 != 32) begin errors++; $display("FAIL period_l1 got %0d want 32", t2 - t1); end
  endtask

  task automatic test_speed;
    int e1;
    int e2;
    int t1;
    int t2;
    int lc3;
    int lc0;
    int exp_t;
    e1 = evt_cnt[1];
    e2 = evt_cnt[2];
    press(3'b010, 8, 40);
    @(negedge clk);
    checks++; if (speed_level !== 2'd2) begin errors++; $display("FAIL faster_level got %0d want 2", speed_level); end
    checks++; if (lvl_chg - evt_cyc[1] != 1) begin errors++; $display("FAIL faster_delay got %0d want 1", lvl_chg - evt_cyc[1]); end
    t1 = first_tick_after(lvl_chg);
    t2 = first_tick_after(t1);
    checks++; if (t1 - lvl_chg != 16) begin errors++; $display("FAIL first_tick_l2 got %0d want 16", t1 - lvl_chg); end
    checks++; if (t1 < 0 || t2 - t1 != 16) begin errors++; $display("FAIL period_l2 got %0d want 16", t2 - t1); end

    press(3'b010, 8, 8);
    lc3 = lvl_chg;
    repeat (3) @(posedge clk);
    press(3'b010, 8, 30);
    @(negedge clk);
    checks++; if (speed_level !== 2'd3) begin errors++; $display("FAIL faster_sat got %0d want 3", speed_level); end
    checks++; if (evt_cnt[1] - e1 != 3) begin errors++; $display("FAIL faster_evts got %0d want 3", evt_cnt[1] - e1); end
    exp_t = lc3 + 8 * ((evt_cyc[1] - lc3) / 8 + 1);
    t1 = first_tick_after(evt_cyc[1]);
    checks++; if (t1 != exp_t) begin errors++; $display("FAIL sat_no_clear got %0d want %0d", t1, exp_t); end

    for (int k = 0; k < 3; k++) press(3'b100, 8, 8);
    lc0 = lvl_chg;
    press(3'b100, 8, 80);
    @(negedge clk);
    checks++; if (speed_level !== 2'd0) begin errors++; $display("FAIL slower_level got %0d want 0", speed_level); end
    checks++; if (evt_cnt[2] - e2 != 4) begin errors++; $display("FAIL slower_evts got %0d want 4", evt_cnt[2] - e2); end
    t1 = first_tick_after(lc0);
    checks++; if (t1 - lc0 != 64) begin errors++; $display("FAIL first_tick_l0 got %0d want 64", t1 - lc0); end
  endtask

  task automatic test_glitch;
    int e1;
    logic [6:0] pat;
    e1 = evt_cnt[1];
    press(3'b010, 3, 15);
    @(negedge clk);
    checks++; if (evt_cnt[1] != e1) begin errors++; $display("FAIL glitch_evt got %0d want 0", evt_cnt[1] - e1); end
    checks++; if (speed_level !== 2'd0) begin errors++; $display("FAIL glitch_level got %0d want 0", speed_level); end
    pat = 7'b1111101;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      raw[1] = pat[i];
    end
    @(posedge clk);
    #1;
    raw[1] = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    checks++; if (evt_cnt[1] - e1 != 1) begin errors++; $display("FAIL bounce_evt got %0d want 1", evt_cnt[1] - e1); end
    checks++; if (speed_level !== 2'd1) begin errors++; $display("FAIL bounce_level got %0d want 1", speed_level); end
  endtask

  task automatic test_back_to_back;
    int e1;
    int e2;
    int tt;
    int t1;
    bit found;
    e1 = evt_cnt[1];
    e2 = evt_cnt[2];
    press(3'b110, 8, 20);
    @(negedge clk);
    checks++; if (evt_cnt[1] - e1 != 1 || evt_cnt[2] - e2 != 1) begin errors++; $display("FAIL both_evts got %0d/%0d want 1/1", evt_cnt[1] - e1, evt_cnt[2] - e2); end
    checks++; if (evt_cyc[1] != evt_cyc[2]) begin errors++; $display("FAIL both_same_cycle got %0d vs %0d", evt_cyc[1], evt_cyc[2]); end
    checks++; if (speed_level !== 2'd1) begin errors++; $display("FAIL both_level got %0d want 1", speed_level); end

    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (step_tick) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL tick_timeout got none want tick"); end
    tt = cyc;
    repeat (3) @(posedge clk);
    #1;
    raw[0] = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    raw[0] = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    checks++; if (run_fall - tt != 10) begin errors++; $display("FAIL pause_at_count got %0d want 10", run_fall - tt); end
    checks++; if (first_tick_after(tt) != -1) begin errors++; $display("FAIL paused_tick got %0d want none", first_tick_after(tt)); end
    press(3'b001, 8, 40);
    @(negedge clk);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL resume_running got %b want 1", running); end
    t1 = first_tick_after(run_rise);
    checks++; if (t1 - run_rise != 22) begin errors++; $display("FAIL resume_tick got %0d want 22", t1 - run_rise); end
  endtask

  task automatic test_reset_mid;
    bit found;
    int nt;
    int ne;
    press(3'b010, 8, 8);
    press(3'b010, 8, 8);
    @(negedge clk);
    checks++; if (speed_level !== 2'd3) begin errors++; $display("FAIL pre_rst_level got %0d want 3", speed_level); end
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (step_tick) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rst_tick_timeout got none want tick"); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL mid_rst_running got %b want 0", running); end
    checks++; if (speed_level !== 2'd1) begin errors++; $display("FAIL mid_rst_level got %0d want 1", speed_level); end
    checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL mid_rst_tick got %b want 0", step_tick); end
    #300;
    rst_n = 1'b1;
    nt = tick_log.size();
    ne = evt_cnt[0] + evt_cnt[1] + evt_cnt[2];
    repeat (50) @(posedge clk);
    @(negedge clk);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL post_rst_running got %b want 0", running); end
    checks++; if (speed_level !== 2'd1) begin errors++; $display("FAIL post_rst_level got %0d want 1", speed_level); end
    checks++; if (tick_log.size() != nt) begin errors++; $display("FAIL post_rst_ticks got %0d want 0", tick_log.size() - nt); end
    checks++; if (evt_cnt[0] + evt_cnt[1] + evt_cnt[2] != ne) begin errors++; $display("FAIL post_rst_evts got %0d want 0", evt_cnt[0] + evt_cnt[1] + evt_cnt[2] - ne); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_pause;
    test_speed;
    test_glitch;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
